dp_geno_dispatcher: RTL
=======================

// Module: dp_geno_dispatcher
// PURPOSE
//  Batch scheduler feeding genotyping jobs to NUM_DP parallel PairHMM DP cores.
//  - Accepts a job stream (payload + geno SRAM address ID).
//  - Tracks per-core busy state and issues each job to an idle core, round-robin.
//  - Reports batch completion once every issued job's result has left its core.
//  - Sits between the geno job fetch logic and the DP core array input ports.
// PARAMETERS
//  NUM_DP   4    number of DP cores; power of two, >=2
//  JOB_W    64   job payload width (read/haplotype descriptors)
//  ADDR_W   $clog2(`GENO_SRAM_WORD_AMOUNT)   geno address ID width
//  CNT_W    16   batch job counter width
// PORTS
//  clk             in   1             clock, rising edge
//  rst             in   1             asynchronous reset, active-high
//  i_start         in   1             pulse: begin batch (honoured only in IDLE)
//  i_job_total     in   CNT_W         jobs in batch; sampled with i_start
//  i_job_valid     in   1             upstream job valid
//  o_job_ready     out  1             upstream job ready
//  i_job_data      in   JOB_W         job payload
//  i_job_addr_ID   in   ADDR_W        geno address ID travelling with job
//  o_dp_valid      out  NUM_DP        one-hot issue valid, per core
//  i_dp_ready      in   NUM_DP        per-core input ready
//  o_dp_data       out  JOB_W         issued payload, shared by all cores
//  o_dp_addr_ID    out  ADDR_W        issued address ID, shared by all cores
//  i_dp_done       in   NUM_DP        per-core pulse: result accepted downstream
//  o_busy_mask     out  NUM_DP        registered per-core busy flags
//  o_jobs_issued   out  CNT_W         jobs issued in current batch
//  o_batch_done    out  1             1-cycle pulse: batch fully drained
//  o_err           out  1             sticky: i_dp_done on a core not busy
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE, hold/target registers empty, rr_ptr=0.
//  FSM:
//   - IDLE  -> RUN on i_start; latch i_job_total, clear o_jobs_issued.
//   - IDLE  -> DONE on i_start with i_job_total==0.
//   - RUN   -> DRAIN when o_jobs_issued==total and hold is empty.
//   - DRAIN -> DONE when o_busy_mask==0.
//   - DONE  -> IDLE after 1 cycle; o_batch_done=1 only in DONE.
//   - i_start outside IDLE is ignored.
//  Intake:
//   - o_job_ready = RUN & !hold_v & (accepted < total).
//   - Accept (valid&ready) loads hold regs; hold_v=1 next cycle.
//  Target select:
//   - When hold_v & !tgt_v & any idle core: tgt = first idle core searching
//     from rr_ptr upward with wrap; tgt_v=1 next cycle.
//   - With no idle core, selection retries every cycle.
//  Issue:
//   - o_dp_valid[tgt] = tgt_v. o_dp_data/o_dp_addr_ID driven from hold regs.
//   - Valid, target and data stay stable until i_dp_ready[tgt].
//   - On handshake: busy[tgt]<=1, hold_v<=0, tgt_v<=0, rr_ptr<=tgt+1 (mod NUM_DP),
//     o_jobs_issued++.
//   - Latency from accept to earliest o_dp_valid: 2 cycles.
//   - Throughput: 1 job per 3 cycles max; intake reopens the cycle after handshake.
//  Completion:
//   - i_dp_done[k] with busy[k] clears busy[k].
//   - i_dp_done[k] with !busy[k] is ignored; o_err<=1 until reset.
//  Simultaneous events:
//   - Issue to core j and done on core k!=j in one cycle: both take effect.
//   - Done on k frees k for selection from the next cycle, not the same cycle.
//   - Multiple done bits in one cycle are all applied.
//  Width/wrap:
//   - Counters are unsigned CNT_W; total <= 2^CNT_W-1, no overflow.
//   - rr_ptr wraps modulo NUM_DP.
//  Reset mid-batch: everything clears immediately, in-flight jobs are dropped;
//  o_batch_done is not pulsed.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/RUN/DRAIN/DONE), NUM_DP default,
//    CNT_W default.
//  - One sub-module, dp_rr_pick: combinational round-robin first-idle finder.
//    Inputs: idle mask and rr_ptr. Outputs: index and found flag. Reusable by
//    the output-side collector.
// TESTING
//  1. total=4, all ready, no done: jobs go to cores 0,1,2,3 in order, 1 job per
//     3 cycles; busy_mask=4'hF; FSM holds DRAIN; o_batch_done stays 0.
//  2. Continue test 1: done[2] -> busy=4'hB; done on the other cores ->
//     o_batch_done pulses exactly once, 1 cycle after busy_mask reaches 0.
//  3. total=6, cores 0-3 busy, hold full: stalls with o_job_ready=0;
//     done[1] -> next job issues to core 1, rr_ptr=2.
//  4. i_dp_ready[tgt]=0 for 5 cycles: o_dp_valid one-hot, data/addr stable
//     throughout, exactly one issue on release.
//  5. total=0 -> o_batch_done pulse 1 cycle after i_start; done[0] while idle ->
//     o_err=1 and stays set.
//  6. rst asserted mid-DRAIN with busy=4'h5: outputs 0 asynchronously; a fresh
//     batch of 2 issues to cores 0 and 1.

Source files
------------

// File: rtl/dp_geno_dispatcher_pkg.sv
// Shared definitions for the genotyping job dispatcher.
//   state_e            : batch FSM encoding (idle / run / drain / done)
//   NumDpDefault       : default number of PairHMM DP cores
//   CntWDefault        : default batch job counter width
//   JobWDefault        : default job payload width
//   AddrWDefault       : default geno address ID width, sized from the geno SRAM depth
package dp_geno_dispatcher_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned NumDpDefault       = 4;
  localparam int unsigned CntWDefault        = 16;
  localparam int unsigned JobWDefault        = 64;
  localparam int unsigned GenoSramWordAmount = 1024;
  localparam int unsigned AddrWDefault       = $clog2(GenoSramWordAmount);

endpackage

// File: rtl/dp_rr_pick.sv
// Combinational round-robin first-set finder.
// Searches i_idle_mask starting at i_rr_ptr and wrapping upward.
//   i_idle_mask : one bit per core, 1 = candidate
//   i_rr_ptr    : index where the search starts
//   o_idx       : first candidate index found (i_rr_ptr when none)
//   o_found     : at least one candidate exists
module dp_rr_pick
  import dp_geno_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_DP = NumDpDefault,
  parameter int unsigned IDX_W  = $clog2(NumDpDefault)
) (
  input  logic [NUM_DP-1:0] i_idle_mask,
  input  logic [IDX_W-1:0]  i_rr_ptr,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_found
);

  always_comb begin
    o_idx   = i_rr_ptr;
    o_found = 1'b0;
    for (int unsigned i = 0; i < NUM_DP; i++) begin
      // NUM_DP is a power of two, so the IDX_W-bit add wraps for free.
      logic [IDX_W-1:0] w_cand;
      w_cand = i_rr_ptr + IDX_W'(i);
      if (!o_found && i_idle_mask[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/dp_geno_dispatcher.sv
// Batch scheduler feeding genotyping jobs to NUM_DP parallel PairHMM DP cores.
// One job is held at a time: accept -> pick an idle core round-robin -> issue.
// Ports:
//   clk, rst                      clock / async active-high reset
//   i_start, i_job_total          begin a batch of i_job_total jobs (IDLE only)
//   i_job_valid/o_job_ready       upstream job handshake, i_job_data/i_job_addr_ID payload
//   o_dp_valid/i_dp_ready         one-hot per-core issue handshake
//   o_dp_data, o_dp_addr_ID       issued payload, shared by all cores
//   i_dp_done                     per-core result-drained pulses
//   o_busy_mask, o_jobs_issued    status
//   o_batch_done                  1-cycle pulse when the batch has fully drained
//   o_err                         sticky: done reported for a core that was not busy
module dp_geno_dispatcher
  import dp_geno_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_DP = NumDpDefault,
  parameter int unsigned JOB_W  = JobWDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_job_total,
  input  logic              i_job_valid,
  output logic              o_job_ready,
  input  logic [JOB_W-1:0]  i_job_data,
  input  logic [ADDR_W-1:0] i_job_addr_ID,
  output logic [NUM_DP-1:0] o_dp_valid,
  input  logic [NUM_DP-1:0] i_dp_ready,
  output logic [JOB_W-1:0]  o_dp_data,
  output logic [ADDR_W-1:0] o_dp_addr_ID,
  input  logic [NUM_DP-1:0] i_dp_done,
  output logic [NUM_DP-1:0] o_busy_mask,
  output logic [CNT_W-1:0]  o_jobs_issued,
  output logic              o_batch_done,
  output logic              o_err
);

  localparam int unsigned IdxW = $clog2(NUM_DP);

  state_e              r_state, w_state_nxt;
  logic                r_hold_v;
  logic [JOB_W-1:0]    r_hold_data;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic                r_tgt_v;
  logic [IdxW-1:0]     r_tgt;
  logic [IdxW-1:0]     r_rr_ptr;
  logic [NUM_DP-1:0]   r_busy;
  logic [CNT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_accepted;
  logic [CNT_W-1:0]    r_issued;
  logic                r_err;

  logic                w_job_ready;
  logic                w_batch_done;
  logic                w_start;
  logic                w_accept;
  logic                w_issue;
  logic [NUM_DP-1:0]   w_dp_valid;
  logic [NUM_DP-1:0]   w_issue_mask;
  logic [NUM_DP-1:0]   w_busy_nxt;
  logic [IdxW-1:0]     w_pick_idx;
  logic                w_pick_found;

  dp_rr_pick #(
    .NUM_DP (NUM_DP),
    .IDX_W  (IdxW)
  ) u_rr_pick (
    .i_idle_mask (~r_busy),
    .i_rr_ptr    (r_rr_ptr),
    .o_idx       (w_pick_idx),
    .o_found     (w_pick_found)
  );

  // Batch FSM next state and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_job_ready  = 1'b0;
    w_batch_done = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_nxt = (i_job_total == '0) ? StDone : StRun;
      end
      StRun: begin
        w_job_ready = !r_hold_v && (r_accepted < r_total);
        if ((r_issued == r_total) && !r_hold_v) w_state_nxt = StDrain;
      end
      StDrain: begin
        if (r_busy == '0) w_state_nxt = StDone;
      end
      StDone: begin
        w_batch_done = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_dp_valid = '0;
    if (r_tgt_v) w_dp_valid[r_tgt] = 1'b1;
  end

  assign w_start      = (r_state == StIdle) && i_start;
  assign w_accept     = i_job_valid && w_job_ready;
  assign w_issue      = r_tgt_v && i_dp_ready[r_tgt];
  assign w_issue_mask = w_issue ? w_dp_valid : '0;
  // A core freed this cycle only becomes selectable once r_busy updates.
  assign w_busy_nxt   = (r_busy & ~i_dp_done) | w_issue_mask;

  // Accept and issue never coincide: accept needs an empty hold, issue a full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_v    <= 1'b0;
      r_hold_data <= '0;
      r_hold_addr <= '0;
      r_tgt_v     <= 1'b0;
      r_tgt       <= '0;
      r_rr_ptr    <= '0;
      r_busy      <= '0;
      r_total     <= '0;
      r_accepted  <= '0;
      r_issued    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_start) begin
        r_total    <= i_job_total;
        r_accepted <= '0;
        r_issued   <= '0;
      end
      if (w_accept) begin
        r_hold_v    <= 1'b1;
        r_hold_data <= i_job_data;
        r_hold_addr <= i_job_addr_ID;
        r_accepted  <= r_accepted + CNT_W'(1);
      end
      if (r_hold_v && !r_tgt_v && w_pick_found) begin
        r_tgt_v <= 1'b1;
        r_tgt   <= w_pick_idx;
      end
      if (w_issue) begin
        r_hold_v <= 1'b0;
        r_tgt_v  <= 1'b0;
        r_rr_ptr <= r_tgt + IdxW'(1);
        r_issued <= r_issued + CNT_W'(1);
      end
      r_busy <= w_busy_nxt;
      if ((i_dp_done & ~r_busy) != '0) r_err <= 1'b1;
    end
  end

  assign o_job_ready   = w_job_ready;
  assign o_dp_valid    = w_dp_valid;
  assign o_dp_data     = r_hold_data;
  assign o_dp_addr_ID  = r_hold_addr;
  assign o_busy_mask   = r_busy;
  assign o_jobs_issued = r_issued;
  assign o_batch_done  = w_batch_done;
  assign o_err         = r_err;

endmodule
